// File: rtl/axi_burst_fetch_if.sv
// axi_burst_fetch_if: AXI4 read-channel bundle (AR + R) between the burst
// fetch master and the interconnect.
//   master modport: drives AR* and RREADY; samples ARREADY and R*.
//   slave modport : the mirror image, used by the interconnect/memory side.
interface axi_burst_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [USER_WIDTH-1:0] aruser;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [USER_WIDTH-1:0] ruser;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, aruser, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, ruser, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, aruser, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi_burst_fetch.sv
// axi_burst_fetch: AXI4 INCR-burst read master feeding the lexer fetch FIFO.
// Streams I_LEN words starting at CMEM_ADDR, one burst outstanding at a time.
// Bursts are cut at BURST_LEN beats, at the end of the transfer and at 4 KiB
// pages, and are only issued once the downstream FIFO reports enough room.
// Ports:
//   CCLK, CRST        clock, synchronous active-high reset
//   CEXEC             start pulse (accepted only when idle)
//   CMEM_ADDR, I_LEN  start byte address and length in words
//   I_FREE            downstream free entries (words)
//   O_VALID/O_DATA    one-cycle strobe per fetched word
//   O_LAST            marks the final word of an error-free transfer
//   BUSY, ERR         transfer in progress / sticky error since last start
//   M_AXI             AXI4 read channels (master modport)
module axi_burst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1,
  parameter int BURST_LEN  = 16,
  parameter int FREE_WIDTH = 12,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  CCLK,
  input  logic                  CRST,
  input  logic                  CEXEC,
  input  logic [ADDR_WIDTH-1:0] CMEM_ADDR,
  input  logic [LEN_WIDTH-1:0]  I_LEN,
  input  logic [FREE_WIDTH-1:0] I_FREE,
  output logic                  O_VALID,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  O_LAST,
  output logic                  BUSY,
  output logic                  ERR,
  axi_burst_fetch_if.master     M_AXI
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  // Comparison width for the free-space check: covers I_FREE and beats+1.
  localparam int CW    = (FREE_WIDTH > 10) ? FREE_WIDTH : 10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  rem_r;
  logic [8:0]            beats_r;
  logic [8:0]            cnt_r;
  logic                  arvalid_r;
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic [7:0]            arlen_r;
  logic                  rready_r;
  logic                  o_valid_r;
  logic [DATA_WIDTH-1:0] o_data_r;
  logic                  o_last_r;
  logic                  busy_r;
  logic                  err_r;

  logic [12:0]           page_bytes_s;
  logic [12:0]           page_words_s;
  logic [8:0]            burst_cap_s;
  logic [8:0]            beats_s;
  logic [9:0]            need_s;
  logic                  space_ok_s;
  logic                  beat_s;
  logic [LEN_WIDTH-1:0]  rem_dec_s;
  logic                  rem_zero_s;
  logic                  last_exp_s;
  logic                  resp_err_s;
  logic                  proto_err_s;
  logic                  err_new_s;
  logic                  unused_s;

  // Words left before the next 4 KiB page boundary.
  assign page_bytes_s = 13'd4096 - {1'b0, addr_r[11:0]};
  assign page_words_s = page_bytes_s >> SHIFT;

  // Burst size: min(BURST_LEN, remaining words, words left in the page).
  always_comb begin
    burst_cap_s = 9'(BURST_LEN);
    beats_s     = 9'(BURST_LEN);
    if (rem_r < LEN_WIDTH'(BURST_LEN)) begin
      burst_cap_s = rem_r[8:0];
    end else begin
      burst_cap_s = 9'(BURST_LEN);
    end
    if (page_words_s < {4'b0000, burst_cap_s}) begin
      beats_s = page_words_s[8:0];
    end else begin
      beats_s = burst_cap_s;
    end
  end

  // A word still sitting in the output register has not yet been counted
  // in I_FREE, so it is reserved on top of the new burst.
  assign need_s     = {1'b0, beats_r} + {9'd0, o_valid_r};
  assign space_ok_s = (CW'(I_FREE) >= CW'(need_s));

  assign beat_s      = M_AXI.rvalid && rready_r;
  assign rem_dec_s   = rem_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign rem_zero_s  = (rem_dec_s == {LEN_WIDTH{1'b0}});
  assign last_exp_s  = (cnt_r == 9'd1);
  assign resp_err_s  = (M_AXI.rresp != 2'b00);
  // RLAST must coincide exactly with the last requested beat.
  assign proto_err_s = (M_AXI.rlast != last_exp_s);
  assign err_new_s   = err_r | resp_err_s | proto_err_s;

  // Control FSM, AR channel registers and output word register.
  always_ff @(posedge CCLK) begin
    if (CRST) begin
      state_r   <= S_IDLE;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      rem_r     <= {LEN_WIDTH{1'b0}};
      beats_r   <= 9'd0;
      cnt_r     <= 9'd0;
      arvalid_r <= 1'b0;
      araddr_r  <= {ADDR_WIDTH{1'b0}};
      arlen_r   <= 8'd0;
      rready_r  <= 1'b0;
      o_valid_r <= 1'b0;
      o_data_r  <= {DATA_WIDTH{1'b0}};
      o_last_r  <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      o_valid_r <= 1'b0;
      o_last_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // BUSY is held through the first idle cycle after DONE; a start
          // request is only accepted once BUSY has dropped.
          if (busy_r) begin
            busy_r <= 1'b0;
          end else if (CEXEC) begin
            addr_r  <= CMEM_ADDR;
            rem_r   <= I_LEN;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= (I_LEN == {LEN_WIDTH{1'b0}}) ? S_DONE : S_CALC;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          beats_r <= beats_s;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (space_ok_s) begin
            arvalid_r <= 1'b1;
            araddr_r  <= addr_r;
            arlen_r   <= beats_r[7:0] - 8'd1;  // 256 beats encodes as 255
            cnt_r     <= beats_r;
            state_r   <= S_ADDR;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_ADDR: begin
          if (M_AXI.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= S_DATA;
          end else begin
            state_r <= S_ADDR;
          end
        end
        S_DATA: begin
          if (beat_s) begin
            o_valid_r <= 1'b1;
            o_data_r  <= M_AXI.rdata;
            o_last_r  <= rem_zero_s && !err_new_s;
            rem_r     <= rem_dec_s;
            addr_r    <= addr_r + ADDR_WIDTH'(BYTES);
            cnt_r     <= cnt_r - 9'd1;
            err_r     <= err_new_s;
            // Burst ends on RLAST or on the expected last beat, whichever
            // comes first; a mismatch between the two is already in err_new_s.
            if (M_AXI.rlast || last_exp_s) begin
              rready_r <= 1'b0;
              state_r  <= (rem_zero_s || err_new_s) ? S_DONE : S_CALC;
            end else begin
              state_r <= S_DATA;
            end
          end else begin
            state_r <= S_DATA;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r   <= S_IDLE;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXI.arid    = {ID_WIDTH{1'b0}};
  assign M_AXI.araddr  = araddr_r;
  assign M_AXI.arlen   = arlen_r;
  assign M_AXI.arsize  = 3'(SHIFT);
  assign M_AXI.arburst = 2'b01;
  assign M_AXI.arlock  = 1'b0;
  assign M_AXI.arcache = 4'b0011;
  assign M_AXI.arprot  = 3'b000;
  assign M_AXI.arqos   = 4'b0000;
  assign M_AXI.aruser  = {USER_WIDTH{1'b0}};
  assign M_AXI.arvalid = arvalid_r;
  assign M_AXI.rready  = rready_r;

  assign O_VALID = o_valid_r;
  assign O_DATA  = o_data_r;
  assign O_LAST  = o_last_r;
  assign BUSY    = busy_r;
  assign ERR     = err_r;

  // RID/RUSER carry nothing for a single-ID, in-order master.
  assign unused_s = ^{M_AXI.rid, M_AXI.ruser};

endmodule
